serial_io_buffer: RTL and testbench

Byte-wide dual FIFO bridge between the processor's serial I/O ports and the external host side of the SoC. The RX FIFO feeds `serial_in`/`serial_valid_in` into the processor. The TX FIFO captures bytes the processor emits on `serial_out`/`serial_wren_out`. The block decouples processor load/store timing from host timing, so store bursts to the serial address do not stall and host input bytes are not lost.

---
 rtl/serial_io_buffer.sv | 135 +++++++++++++
 tb/tb_serial_io_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_io_buffer.sv
// serial_io_buffer
//
// Purpose: byte-wide dual FIFO bridge between the processor serial I/O ports
// and the external host. The RX FIFO carries host bytes to the processor, the
// TX FIFO carries processor stores to the host. Both FIFOs are
// first-word-fall-through: the head byte is visible combinationally and reads
// 8'h00 whenever its FIFO is empty.
//
// Ports:
//   clock            single clock, rising edge
//   reset            synchronous, active-low
//   host_rx_data     byte from host            host_rx_valid   host offers byte
//   host_rx_ready    RX FIFO can accept
//   host_tx_data     TX head byte              host_tx_valid   TX non-empty
//   host_tx_ready    host consumes TX head
//   serial_in        RX head byte              serial_valid_in RX non-empty
//   serial_rden_out  processor consumes RX head
//   serial_out       processor store byte      serial_wren_out store strobe
//   serial_ready_in  TX FIFO can accept
//
// Optional feature (macro SERIAL_IO_STATUS_EN):
//   rx_count, tx_count        registered occupancy, DEPTH_LOG2+1 bits
//   rx_underflow, tx_overflow sticky error flags, cleared only by reset
// Without the macro those ports and the sticky registers do not exist.

module serial_io_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] host_rx_data,
  input  logic       host_rx_valid,
  output logic       host_rx_ready,
  output logic [7:0] host_tx_data,
  output logic       host_tx_valid,
  input  logic       host_tx_ready,
  output logic [7:0] serial_in,
  output logic       serial_valid_in,
  input  logic       serial_rden_out,
  input  logic [7:0] serial_out,
  input  logic       serial_wren_out,
  output logic       serial_ready_in
`ifdef SERIAL_IO_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic [DEPTH_LOG2:0] tx_count,
  output logic                rx_underflow,
  output logic                tx_overflow
`endif
);

  localparam int Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FullCount = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0]   CntOne    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PtrOne    = DEPTH_LOG2'(1);

  logic [7:0]            rxMem [Depth];
  logic [7:0]            txMem [Depth];
  logic [DEPTH_LOG2-1:0] rxWrPtr, rxRdPtr, txWrPtr, txRdPtr;
  logic [DEPTH_LOG2:0]   rxCount, txCount;
  logic                  rxFull, txFull, rxPush, rxPop, txPush, txPop;

  // Handshakes are gated by reset so that the reset cycle shows both
  // readies and valids low, which also guarantees no push or pop then.
  assign rxFull          = (rxCount == FullCount);
  assign txFull          = (txCount == FullCount);
  assign host_rx_ready   = reset & ~rxFull;
  assign serial_ready_in = reset & ~txFull;
  assign serial_valid_in = reset & (rxCount != '0);
  assign host_tx_valid   = reset & (txCount != '0);

  assign rxPush = host_rx_valid & host_rx_ready;
  assign rxPop  = serial_rden_out & serial_valid_in;
  assign txPush = serial_wren_out & serial_ready_in;
  assign txPop  = host_tx_ready & host_tx_valid;

  assign serial_in    = serial_valid_in ? rxMem[rxRdPtr] : 8'h00;
  assign host_tx_data = host_tx_valid   ? txMem[txRdPtr] : 8'h00;

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (rxPush) rxMem[rxWrPtr] <= host_rx_data;
    if (txPush) txMem[txWrPtr] <= serial_out;
  end

  // RX pointers and occupancy; pointers wrap naturally at their width.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
      rxCount <= '0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + PtrOne;
      if (rxPop)  rxRdPtr <= rxRdPtr + PtrOne;
      if (rxPush && !rxPop)      rxCount <= rxCount + CntOne;
      else if (!rxPush && rxPop) rxCount <= rxCount - CntOne;
    end
  end

  // TX pointers and occupancy, mirror of the RX side.
  always_ff @(posedge clock) begin
    if (!reset) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + PtrOne;
      if (txPop)  txRdPtr <= txRdPtr + PtrOne;
      if (txPush && !txPop)      txCount <= txCount + CntOne;
      else if (!txPush && txPop) txCount <= txCount - CntOne;
    end
  end

`ifdef SERIAL_IO_STATUS_EN
  logic rxUnderflow, txOverflow;

  // Sticky error flags: a store into a full TX FIFO or a read of an empty
  // RX FIFO is recorded until the next reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rxUnderflow <= 1'b0;
      txOverflow  <= 1'b0;
    end else begin
      if (serial_rden_out && !serial_valid_in) rxUnderflow <= 1'b1;
      if (serial_wren_out && !serial_ready_in) txOverflow  <= 1'b1;
    end
  end

  assign rx_count     = rxCount;
  assign tx_count     = txCount;
  assign rx_underflow = rxUnderflow;
  assign tx_overflow  = txOverflow;
`endif

endmodule

// File: tb/tb_serial_io_buffer.sv
// Testbench for serial_io_buffer. Stimulus pushes expected bytes into one
// queue per direction; a monitor pops and compares on every consumed byte.

module tb_serial_io_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready;
  logic [7:0] host_tx_data;
  logic       host_tx_valid;
  logic       host_tx_ready;
  logic [7:0] serial_in;
  logic       serial_valid_in;
  logic       serial_rden_out;
  logic [7:0] serial_out;
  logic       serial_wren_out;
  logic       serial_ready_in;
`ifdef SERIAL_IO_STATUS_EN
  logic [4:0] rxCountOut, txCountOut;
  logic       rxUnderflowOut, txOverflowOut;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] rxExp[$];
  logic [7:0] txExp[$];

  always #5 clock = ~clock;

  serial_io_buffer #(.DEPTH_LOG2(4)) dut (
    .clock(clock),
    .reset(reset),
    .host_rx_data(host_rx_data),
    .host_rx_valid(host_rx_valid),
    .host_rx_ready(host_rx_ready),
    .host_tx_data(host_tx_data),
    .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready),
    .serial_in(serial_in),
    .serial_valid_in(serial_valid_in),
    .serial_rden_out(serial_rden_out),
    .serial_out(serial_out),
    .serial_wren_out(serial_wren_out),
    .serial_ready_in(serial_ready_in)
`ifdef SERIAL_IO_STATUS_EN
    ,
    .rx_count(rxCountOut),
    .tx_count(txCountOut),
    .rx_underflow(rxUnderflowOut),
    .tx_overflow(txOverflowOut)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rxValid, input logic [7:0] rxData,
                               input logic wren, input logic [7:0] wrData,
                               input logic rden, input logic txReady);
    host_rx_valid   = rxValid;
    host_rx_data    = rxData;
    serial_wren_out = wren;
    serial_out      = wrData;
    serial_rden_out = rden;
    host_tx_ready   = txReady;
  endtask

  // Monitor: sampled on the falling edge, a pop will happen at the next
  // rising edge, so the presented head byte must match the queue front.
  always @(negedge clock) begin
    if (serial_valid_in && serial_rden_out) begin
      if (rxExp.size() == 0) checkOutput("rxUnexpectedByte", 32'(serial_in), 32'hFFFF_FFFF);
      else checkOutput("rxData", 32'(serial_in), 32'(rxExp.pop_front()));
    end
    if (host_tx_valid && host_tx_ready) begin
      if (txExp.size() == 0) checkOutput("txUnexpectedByte", 32'(host_tx_data), 32'hFFFF_FFFF);
      else checkOutput("txData", 32'(host_tx_data), 32'(txExp.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rxBytes [40];
    logic [7:0] txBytes [40];
    int rxIdx, txIdx, cycles;

    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset held for two cycles, then released.
    tick();
    tick();
    checkOutput("resetRxReady", 32'(host_rx_ready), 32'd0);
    checkOutput("resetTxReady", 32'(serial_ready_in), 32'd0);
    checkOutput("resetSerialValid", 32'(serial_valid_in), 32'd0);
    checkOutput("resetHostTxValid", 32'(host_tx_valid), 32'd0);
    checkOutput("resetSerialIn", 32'(serial_in), 32'd0);
    checkOutput("resetHostTxData", 32'(host_tx_data), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("firstCycleRxReady", 32'(host_rx_ready), 32'd1);
    checkOutput("firstCycleTxReady", 32'(serial_ready_in), 32'd1);
`ifdef SERIAL_IO_STATUS_EN
    checkOutput("resetRxCount", 32'(rxCountOut), 32'd0);
    checkOutput("resetTxCount", 32'(txCountOut), 32'd0);
    checkOutput("resetUnderflow", 32'(rxUnderflowOut), 32'd0);
    checkOutput("resetOverflow", 32'(txOverflowOut), 32'd0);
`endif
    tick();

    // RX ordering: 8'h48 then 8'h69 from the host.
    applyStimulus(1'b1, 8'h48, 1'b0, 8'h00, 1'b0, 1'b0);
    rxExp.push_back(8'h48);
    tick();
    checkOutput("rxFirstValid", 32'(serial_valid_in), 32'd1);
    checkOutput("rxFirstHead", 32'(serial_in), 32'h48);
    applyStimulus(1'b1, 8'h69, 1'b0, 8'h00, 1'b0, 1'b0);
    rxExp.push_back(8'h69);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rxSecondHead", 32'(serial_in), 32'h69);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rxEmptyAfterPops", 32'(serial_valid_in), 32'd0);
    checkOutput("rxEmptyHeadZero", 32'(serial_in), 32'd0);

    // Read of the empty RX FIFO is ignored but recorded.
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rxStillEmpty", 32'(serial_valid_in), 32'd0);
`ifdef SERIAL_IO_STATUS_EN
    checkOutput("rxUnderflowSet", 32'(rxUnderflowOut), 32'd1);
`endif

    // TX full: 16 stores with the host stalled, then a dropped 17th.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 8'(i), 1'b0, 1'b0);
      txExp.push_back(8'(i));
      tick();
    end
    checkOutput("txFullReady", 32'(serial_ready_in), 32'd0);
    checkOutput("txFullHead", 32'(host_tx_data), 32'h00);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef SERIAL_IO_STATUS_EN
    checkOutput("txOverflowSet", 32'(txOverflowOut), 32'd1);
    checkOutput("txCountFull", 32'(txCountOut), 32'd16);
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 40 && txExp.size() > 0; c++) tick();
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("txDrainRemaining", 32'(txExp.size()), 32'd0);
    checkOutput("txEmptyAfterDrain", 32'(host_tx_valid), 32'd0);

    // Reset clears the sticky flags before the flag-free traffic below.
    reset = 1'b0;
    tick();
    reset = 1'b1;
`ifdef SERIAL_IO_STATUS_EN
    checkOutput("flagsClearedUnderflow", 32'(rxUnderflowOut), 32'd0);
    checkOutput("flagsClearedOverflow", 32'(txOverflowOut), 32'd0);
`endif

    // Simultaneous push and pop with three bytes queued.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 8'h00, 1'b0, 1'b0);
      rxExp.push_back(8'(8'h11 * (i + 1)));
      tick();
    end
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0);
    rxExp.push_back(8'h55);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("simulHeadAdvanced", 32'(serial_in), 32'h22);
`ifdef SERIAL_IO_STATUS_EN
    checkOutput("simulCountSame", 32'(rxCountOut), 32'd3);
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("simulOneLeft", 32'(serial_valid_in), 32'd1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("simulDrainedAfterThree", 32'(serial_valid_in), 32'd0);

    // Wrap-around: 40 random bytes per direction with random handshakes.
    for (int i = 0; i < 40; i++) begin
      rxBytes[i] = 8'($urandom);
      txBytes[i] = 8'($urandom);
    end
    rxIdx = 0;
    txIdx = 0;
    cycles = 0;
    while ((rxIdx < 40 || txIdx < 40 || rxExp.size() > 0 || txExp.size() > 0)
           && cycles < 2000) begin
      host_rx_valid   = (rxIdx < 40) && ($urandom_range(0, 3) != 0);
      host_rx_data    = (rxIdx < 40) ? rxBytes[rxIdx] : 8'h00;
      serial_wren_out = (txIdx < 40) && ($urandom_range(0, 3) != 0);
      serial_out      = (txIdx < 40) ? txBytes[txIdx] : 8'h00;
      serial_rden_out = serial_valid_in && ($urandom_range(0, 2) != 0);
      host_tx_ready   = $urandom_range(0, 2) != 0;
      if (host_rx_valid && host_rx_ready) begin
        rxExp.push_back(rxBytes[rxIdx]);
        rxIdx++;
      end
      if (serial_wren_out && serial_ready_in) begin
        txExp.push_back(txBytes[txIdx]);
        txIdx++;
      end
      tick();
      cycles++;
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("wrapCompletedInBudget", 32'(cycles < 2000), 32'd1);
    checkOutput("wrapRxAllSent", 32'(rxIdx), 32'd40);
    checkOutput("wrapTxAllSent", 32'(txIdx), 32'd40);
`ifdef SERIAL_IO_STATUS_EN
    checkOutput("wrapNoUnderflow", 32'(rxUnderflowOut), 32'd0);
    checkOutput("wrapNoOverflow", 32'(txOverflowOut), 32'd0);
`endif

    // Reset mid-stream: 5 RX bytes and 2 TX bytes are discarded.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'hA0 + i), i < 2, 8'(8'hB0 + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("preResetRxValid", 32'(serial_valid_in), 32'd1);
    checkOutput("preResetTxValid", 32'(host_tx_valid), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checkOutput("postResetRxValid", 32'(serial_valid_in), 32'd0);
    checkOutput("postResetTxValid", 32'(host_tx_valid), 32'd0);
    applyStimulus(1'b1, 8'h7E, 1'b0, 8'h00, 1'b0, 1'b0);
    rxExp.push_back(8'h7E);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("postResetFirstByte", 32'(serial_in), 32'h7E);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("postResetEmpty", 32'(serial_valid_in), 32'd0);
    tick();
    checkOutput("rxQueueEmpty", 32'(rxExp.size()), 32'd0);
    checkOutput("txQueueEmpty", 32'(txExp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
